uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: data_size, 8, number of data bits per frame, legal range 1-10.
REQ-002 Parameter: clk_freq, 10000, clock frequency in Hz.
REQ-003 Parameter: baud_rate, 2000, bit rate in baud.
REQ-004 Parameter: div, clk_freq/baud_rate (5), clock cycles per bit; half = div/2, integer division (2).
REQ-005 Port: clk  input  1  sole clock, all flops on posedge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: rx  input  1  serial line, asynchronous, idles high.
REQ-008 Port: data  output  10  received word, bits above data_size-1 zero.
REQ-009 Port: valid  output  1  one-cycle pulse, frame complete, data and flags updated.
REQ-010 Port: parity_err  output  1  even-parity mismatch on last frame.
REQ-011 Port: frame_err  output  1  stop bit sampled low on last frame.
REQ-012 Port: busy  output  1  high from start-edge detection until return to IDLE.

Function
REQ-013 Frame format SHALL be start(0), data_size data bits LSB first, one even-parity bit (XOR of data bits), stop(1).
REQ-014 rx SHALL pass a two-flop synchronizer; rx_s denotes its output; all decisions use rx_s only.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP; one bit-cycle counter cnt and one bit index idx.
REQ-016 IDLE: rx_s==0 with previous rx_s==1 (falling edge) -> START, cnt<=0, busy<=1; no edge -> stay, busy<=0.
REQ-017 START: cnt increments each cycle; at cnt==half-1, rx_s==0 -> DATA, cnt<=0, idx<=0; rx_s==1 -> IDLE, busy<=0, no valid (glitch rejection).
REQ-018 DATA: at cnt==div-1, sample rx_s into shift bit idx, cnt<=0; idx==data_size-1 -> PARITY, else idx+1.
REQ-019 PARITY: at cnt==div-1, capture parity bit, cnt<=0 -> STOP.
REQ-020 STOP: at cnt==div-1, sample stop bit -> IDLE; next cycle data, parity_err=^(data bits, parity bit), frame_err=~stop, valid=1.
REQ-021 Sampling SHALL land at bit-centre ±1 cycle relative to detected start edge.
REQ-022 valid SHALL assert on every completed frame, including error frames; flags SHALL be read with valid.
REQ-023 data, parity_err, frame_err SHALL hold their values until the next valid.
REQ-024 After a frame_err, a new frame SHALL require rx_s to return high before a falling edge is accepted.
REQ-025 Back-to-back frames: a falling edge in the first IDLE cycle after STOP SHALL be detected; the pending valid SHALL still pulse.
REQ-026 cnt SHALL never exceed div-1; no state SHALL persist longer than div cycles without rx activity except IDLE.
REQ-027 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, cnt=0, idx=0, synchronizer flops=1, data=0, valid=0, parity_err=0, frame_err=0, busy=0.
REQ-029 reset asserted mid-frame SHALL abandon the frame with no valid; after release, receiver SHALL wait for a fresh falling edge.

Verification
REQ-030 Frame 0xA5 (parity 0, stop 1) at 5 clk/bit -> one valid pulse, data=0x0A5, parity_err=0, frame_err=0, busy low after.
REQ-031 Frame 0x01 with parity bit forced 0 -> valid, data=0x001, parity_err=1, frame_err=0.
REQ-032 Frame 0xFF with stop bit 0, line held low 20 cycles -> valid, data=0x0FF, frame_err=1; no second frame until rx high then low.
REQ-033 rx low for 1 cycle only (glitch) -> busy pulses, returns to IDLE, no valid, outputs unchanged.
REQ-034 Two frames 0x3C, 0xC3 with zero idle gap -> two valid pulses, data 0x03C then 0x0C3, no errors.
REQ-035 reset low during DATA bit 3 -> all outputs 0 immediately; after release, clean frame 0x55 -> valid, data=0x055.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-word outputs of the UART receiver
interface uart_rx_if;
    logic       rx;
    logic [9:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport slave  (input rx, output data, valid, parity_err, frame_err, busy);
    modport master (output rx, input data, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, data LSB first, even parity, stop
module uart_rx #(
    parameter int data_size = 8,
    parameter int clk_freq  = 10000,
    parameter int baud_rate = 2000
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int div  = clk_freq / baud_rate;
    localparam int half = div / 2;
    localparam int cw   = (div > 1) ? $clog2(div) : 1;
    localparam logic [cw-1:0] cnt_last = cw'(div - 1);
    localparam logic [cw-1:0] cnt_half = cw'(half - 1);
    localparam logic [3:0]    idx_last = 4'(data_size - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_m, rx_s, rx_p;
    logic [cw-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [9:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          busy_q, busy_d;
    logic          done;
    logic [9:0]    data_q;
    logic          valid_q, perr_q, ferr_q;

    // rx_p is the previous synchronized sample, used only for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        busy_d  = busy_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_p && !rx_s) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            START: begin
                if (cnt_q == cnt_half) begin
                    cnt_d = '0;
                    // a line that is already high again at mid-start was a glitch
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                        shift_d = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == cnt_last) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == idx_last) state_d = PARITY;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == cnt_last) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == cnt_last) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Result registers hold until the next completed frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= done;
            if (done) begin
                data_q <= shift_q;
                perr_q <= (^shift_q) ^ par_q;
                ferr_q <= ~rx_s;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed frames
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if bus();

    uart_rx #(.data_size(8), .clk_freq(10000), .baud_rate(2000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [9:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("data", 32'(bus.data), 32'(mon_e.data));
                check("parity_err", 32'(bus.parity_err), 32'(mon_e.perr));
                check("frame_err", 32'(bus.frame_err), 32'(mon_e.ferr));
            end
        end
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [9:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic push(input logic [9:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   base;
        logic seen;
        bus.rx = 1'b1;
        reset  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_perr", 32'(bus.parity_err), 32'h0);
        check("rst_ferr", 32'(bus.frame_err), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        push(10'h0A5, 1'b0, 1'b0);
        send_frame(10'h0A5, 1'b0, 1'b1);
        wait_drain("a5");
        repeat (3) @(posedge clk);
        #1;
        check("a5_busy_after", 32'(bus.busy), 32'h0);

        push(10'h001, 1'b1, 1'b0);
        send_frame(10'h001, 1'b0, 1'b1);
        wait_drain("01_bad_parity");

        push(10'h0FF, 1'b0, 1'b1);
        send_frame(10'h0FF, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        wait_drain("ff_bad_stop");
        check("ff_no_rearm", 32'(n_valid), 32'd3);
        bus.rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        base   = n_valid;
        bus.rx = 1'b0;
        @(posedge clk);
        #1;
        bus.rx = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | bus.busy;
        end
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy_pulse", 32'(seen), 32'h1);
        check("glitch_busy_after", 32'(bus.busy), 32'h0);
        check("glitch_no_valid", 32'(n_valid), 32'(base));
        check("glitch_data_hold", 32'(bus.data), 32'h0FF);
        check("glitch_ferr_hold", 32'(bus.frame_err), 32'h1);

        push(10'h03C, 1'b0, 1'b0);
        push(10'h0C3, 1'b0, 1'b0);
        send_frame(10'h03C, 1'b0, 1'b1);
        send_frame(10'h0C3, 1'b0, 1'b1);
        wait_drain("back_to_back");
        check("b2b_count", 32'(n_valid), 32'd5);

        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        bus.rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_data", 32'(bus.data), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_perr", 32'(bus.parity_err), 32'h0);
        check("mid_rst_ferr", 32'(bus.frame_err), 32'h0);
        bus.rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid_no_valid", 32'(n_valid), 32'd5);

        push(10'h055, 1'b0, 1'b0);
        send_frame(10'h055, 1'b0, 1'b1);
        wait_drain("55_after_reset");
        repeat (5) @(posedge clk);
        #1;
        check("total_valid", 32'(n_valid), 32'd6);
        check("final_data", 32'(bus.data), 32'h055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
